// File: rtl/window_buffer_if.sv
// rtl/window_buffer_if.sv - pixel-in / window-out bundle for window_buffer
interface window_buffer_if #(
    parameter int WS = 5,
    parameter int DW = 8
);
    logic                  iValid;
    logic [DW-1:0]         iData;
    logic                  iSoF;
    logic                  oValid;
    logic [WS*WS*DW-1:0]   oWin;
    logic [4:0]            oRow;
    logic [4:0]            oCol;

    modport master (output iValid, iData, iSoF, input oValid, oWin, oRow, oCol);
    modport slave  (input iValid, iData, iSoF, output oValid, oWin, oRow, oCol);
endinterface

// File: rtl/window_buffer.sv
// rtl/window_buffer.sv - raster-scan WS x WS sliding window with stride gating
module window_buffer #(
    parameter int XS     = 32,
    parameter int WS     = 5,
    parameter int STRIDE = 1,
    parameter int DW     = 8
) (
    input  logic            iCLK,
    input  logic            iRSTn,
    window_buffer_if.slave  bus
);
    localparam logic [4:0] LAST  = 5'(XS - 1);
    localparam logic [4:0] EDGE  = 5'(WS - 1);
    localparam logic [4:0] PLAST = 5'(STRIDE - 1);

    logic [4:0] col_q, row_q, cph_q, rph_q;
    logic [4:0] col_d, row_d, cph_d, rph_d;
    logic [4:0] cur_col, cur_row, cur_cph, cur_rph;
    logic [4:0] orow_q, ocol_q;
    logic       valid_q, hit, sof, col_wrap, row_wrap;

    logic [DW-1:0] lb_q  [WS-1][XS];
    logic [DW-1:0] win_q [WS][WS];
    logic [DW-1:0] newcol [WS];

    // A qualified start-of-frame overrides the counters for this very pixel.
    always_comb begin
        sof      = bus.iValid & bus.iSoF;
        cur_col  = sof ? 5'd0 : col_q;
        cur_row  = sof ? 5'd0 : row_q;
        cur_cph  = sof ? 5'd0 : cph_q;
        cur_rph  = sof ? 5'd0 : rph_q;
        col_wrap = (cur_col == LAST);
        row_wrap = (cur_row == LAST);
        col_d    = col_wrap ? 5'd0 : cur_col + 5'd1;
        row_d    = col_wrap ? (row_wrap ? 5'd0 : cur_row + 5'd1) : cur_row;
        cph_d    = (col_wrap || cur_col < EDGE) ? 5'd0
                 : ((cur_cph == PLAST) ? 5'd0 : cur_cph + 5'd1);
        rph_d    = cur_rph;
        if (col_wrap)
            rph_d = (row_wrap || cur_row < EDGE) ? 5'd0
                  : ((cur_rph == PLAST) ? 5'd0 : cur_rph + 5'd1);
        hit      = (cur_row >= EDGE) && (cur_col >= EDGE)
                && (cur_cph == 5'd0) && (cur_rph == 5'd0);
    end

    // lb_q[0] holds the previous row; lb_q[WS-2] the oldest, i.e. the window's top row.
    always_comb begin
        for (int r = 0; r < WS - 1; r++)
            newcol[r] = lb_q[WS-2-r][cur_col];
        newcol[WS-1] = bus.iData;
    end

    always_ff @(posedge iCLK) begin
        if (bus.iValid) begin
            lb_q[0][cur_col] <= bus.iData;
            for (int k = 1; k < WS - 1; k++)
                lb_q[k][cur_col] <= lb_q[k-1][cur_col];
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            col_q   <= '0;
            row_q   <= '0;
            cph_q   <= '0;
            rph_q   <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
            valid_q <= 1'b0;
            for (int r = 0; r < WS; r++)
                for (int c = 0; c < WS; c++)
                    win_q[r][c] <= '0;
        end else begin
            valid_q <= bus.iValid && hit;
            if (bus.iValid) begin
                col_q  <= col_d;
                row_q  <= row_d;
                cph_q  <= cph_d;
                rph_q  <= rph_d;
                orow_q <= cur_row;
                ocol_q <= cur_col;
                for (int r = 0; r < WS; r++) begin
                    for (int c = 0; c < WS - 1; c++)
                        win_q[r][c] <= win_q[r][c+1];
                    win_q[r][WS-1] <= newcol[r];
                end
            end
        end
    end

    always_comb begin
        bus.oWin = '0;
        for (int r = 0; r < WS; r++)
            for (int c = 0; c < WS; c++)
                bus.oWin[(r*WS+c)*DW +: DW] = win_q[r][c];
        bus.oValid = valid_q;
        bus.oRow   = orow_q;
        bus.oCol   = ocol_q;
    end
endmodule

// File: tb/tb_window_buffer.sv
// tb/tb_window_buffer.sv - directed bench for window_buffer at strides 1 and 2
module tb_window_buffer;
    logic iCLK = 1'b0;
    logic iRSTn;
    always #5 iCLK = ~iCLK;

    window_buffer_if #(.WS(5), .DW(8)) bus1 ();
    window_buffer_if #(.WS(5), .DW(8)) bus2 ();

    window_buffer #(.XS(32), .WS(5), .STRIDE(1), .DW(8)) u_s1 (.iCLK(iCLK), .iRSTn(iRSTn), .bus(bus1));
    window_buffer #(.XS(32), .WS(5), .STRIDE(2), .DW(8)) u_s2 (.iCLK(iCLK), .iRSTn(iRSTn), .bus(bus2));

    int tests = 0, fails = 0;
    int er, ec, lr, lc;
    int pulses1, pulses2, mism;
    int q1[$], q2[$];
    bit have_first, last_valid;
    logic [199:0] first_win, last_win;
    int first_rc;

    function automatic logic [7:0] ramp(int r, int c);
        return 8'((r * 32 + c) & 255);
    endfunction

    function automatic logic [199:0] exp_win(int R, int C);
        logic [199:0] w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[(r*5+c)*8 +: 8] = ramp(R - 4 + r, C - 4 + c);
        return w;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic s);
        bus1.iValid = v; bus1.iData = d; bus1.iSoF = s;
        bus2.iValid = v; bus2.iData = d; bus2.iSoF = s;
    endtask

    task automatic seg();
        pulses1 = 0; pulses2 = 0; mism = 0;
        q1.delete(); q2.delete();
        have_first = 0;
    endtask

    task automatic push(input bit sof);
        logic [199:0] w;
        bit e1, e2;
        if (sof) begin er = 0; ec = 0; end
        drive(1'b1, ramp(er, ec), sof);
        @(posedge iCLK); #1;
        e1 = (er >= 4) && (ec >= 4);
        e2 = e1 && ((er - 4) % 2 == 0) && ((ec - 4) % 2 == 0);
        w  = exp_win(er, ec);
        if (bus1.oValid !== e1) mism++;
        if (bus2.oValid !== e2) mism++;
        if (bus1.oValid === 1'b1) begin
            pulses1++;
            q1.push_back(int'(bus1.oRow) * 32 + int'(bus1.oCol));
            if (!have_first) begin
                have_first = 1;
                first_win  = bus1.oWin;
                first_rc   = int'(bus1.oRow) * 32 + int'(bus1.oCol);
            end
        end
        if (bus2.oValid === 1'b1) begin
            pulses2++;
            q2.push_back(int'(bus2.oRow) * 32 + int'(bus2.oCol));
        end
        if (e1 && (bus1.oWin !== w || bus1.oRow !== 5'(er) || bus1.oCol !== 5'(ec))) mism++;
        if (e2 && (bus2.oWin !== w || bus2.oRow !== 5'(er) || bus2.oCol !== 5'(ec))) mism++;
        last_valid = e1; last_win = w; lr = er; lc = ec;
        if (ec == 31) begin ec = 0; er = (er == 31) ? 0 : er + 1; end
        else ec++;
    endtask

    // iSoF is raised on idle cycles on purpose: it must be ignored without iValid.
    task automatic idle();
        drive(1'b0, 8'($urandom_range(0, 255)), 1'b1);
        @(posedge iCLK); #1;
        if (bus1.oValid !== 1'b0 || bus2.oValid !== 1'b0) mism++;
        if (bus1.oRow !== 5'(lr) || bus1.oCol !== 5'(lc)) mism++;
        if (last_valid && bus1.oWin !== last_win) mism++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid1"}, 200'(bus1.oValid), 200'(0));
        check({tag, "_valid2"}, 200'(bus2.oValid), 200'(0));
        check({tag, "_win"},    bus1.oWin, 200'(0));
        check({tag, "_row"},    200'(bus1.oRow), 200'(0));
        check({tag, "_col"},    200'(bus1.oCol), 200'(0));
    endtask

    initial begin
        iRSTn = 1'b0;
        drive(1'b0, 8'd0, 1'b0);
        er = 0; ec = 0; lr = 0; lc = 0; last_valid = 0; last_win = '0;
        repeat (3) @(posedge iCLK);
        #1;
        check_zero("reset_init");
        iRSTn = 1'b1;

        // Continuous ramp frame
        seg();
        repeat (1024) push(1'b0);
        check("ramp_pulses_s1",   200'(pulses1), 200'(784));
        check("ramp_pulses_s2",   200'(pulses2), 200'(196));
        check("ramp_window_mism", 200'(mism), 200'(0));
        check("ramp_first_rc",    200'(first_rc), 200'(4*32+4));
        check("ramp_first_tl",    200'(first_win[7:0]), 200'(0));
        check("ramp_first_tr",    200'(first_win[39:32]), 200'(4));
        check("ramp_first_br",    200'(first_win[199:192]), 200'(132));
        check("s2_pulse0",        200'(qget(q2, 0)), 200'(4*32+4));
        check("s2_pulse1",        200'(qget(q2, 1)), 200'(4*32+6));
        check("s2_pulse13",       200'(qget(q2, 13)), 200'(4*32+30));
        check("s2_pulse14",       200'(qget(q2, 14)), 200'(6*32+4));

        // Same frame with iValid toggling
        seg();
        repeat (1024) begin push(1'b0); idle(); end
        check("toggle_pulses_s1", 200'(pulses1), 200'(784));
        check("toggle_pulses_s2", 200'(pulses2), 200'(196));
        check("toggle_mism",      200'(mism), 200'(0));

        // Two back-to-back frames with no idle and no iSoF
        seg();
        repeat (1024) push(1'b0);
        check("b2b_f1_pulses", 200'(pulses1), 200'(784));
        check("b2b_f1_mism",   200'(mism), 200'(0));
        seg();
        repeat (1024) push(1'b0);
        check("b2b_f2_pulses", 200'(pulses1), 200'(784));
        check("b2b_f2_first",  200'(qget(q1, 0)), 200'(4*32+4));
        check("b2b_f2_mism",   200'(mism), 200'(0));

        // Reset pulsed right after accepting (10,7)
        seg();
        repeat (10*32 + 8) push(1'b0);
        check("pre_reset_valid", 200'(bus1.oValid), 200'(1));
        iRSTn = 1'b0;
        #1;
        check_zero("reset_async");
        @(posedge iCLK); #1;
        check_zero("reset_held");
        iRSTn = 1'b1;
        er = 0; ec = 0; last_valid = 0;
        seg();
        repeat (1024) push(1'b0);
        check("rst_pulses", 200'(pulses1), 200'(784));
        check("rst_first",  200'(qget(q1, 0)), 200'(4*32+4));
        check("rst_mism",   200'(mism), 200'(0));

        // iSoF arrives with the pixel that would have been (12,20)
        seg();
        repeat (12*32 + 20) push(1'b0);
        seg();
        push(1'b1);
        repeat (1023) push(1'b0);
        check("sof_first",     200'(qget(q1, 0)), 200'(4*32+4));
        check("sof_pulses_s1", 200'(pulses1), 200'(784));
        check("sof_pulses_s2", 200'(pulses2), 200'(196));
        check("sof_mism",      200'(mism), 200'(0));

        drive(1'b0, 8'd0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
